alu_seq_n: RTL and testbench
============================

Name: alu_seq_n

Overview:
Parametrised, registered N-bit ALU with valid/ready input handshake, status flags and a multi-cycle shift-add multiplier. It extends the 2-bit-op combinational ALU to an 8-op, clocked unit. The legacy op encodings are kept in op[1:0] with op[2]=0. It sits between the operand register file and the result writeback stage.

Parameters:
N, 4, operand/result width in bits; legal N >= 2.

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous, active-high reset
in_valid  in  1  operands/op valid
in_ready  out  1  block can accept; high in IDLE
a  in  N  operand A (unsigned; signed for ovf)
b  in  N  operand B / shift amount
op  in  3  operation select
out_valid  out  1  one-cycle pulse: result/flags updated
result  out  N  result (low half for MUL)
result_hi  out  N  high half of MUL product; 0 for other ops
carry  out  1  carry/borrow flag
zero  out  1  result (full 2N for MUL) == 0
ovf  out  1  overflow flag
err  out  1  illegal-op flag

Behaviour:
- Reset, synchronous: in_ready=1. out_valid, result, result_hi, carry, zero, ovf, err all 0. FSM goes to IDLE.
- Accept: in_valid && in_ready at a rising edge E0. in_valid while in_ready=0 is ignored; it is not queued.
- Op encoding and results:
  - 000 ADD: a+b. carry = bit N of the sum.
  - 001 OR: a|b.
  - 010 SUB: a-b mod 2^N. carry = borrow, i.e. a<b unsigned.
  - 011 XOR: a^b.
  - 100 AND: a&b.
  - 101 SHL: a<<b.
  - 110 SHR: a>>b (logical). For both shifts, b is unsigned; b >= N gives 0.
  - 111 MUL: unsigned a*b, 2N-bit product as {result_hi, result}.
- Flags:
  - carry = 0 for all ops except ADD/SUB.
  - ovf = two's-complement overflow for ADD/SUB.
  - ovf = (result_hi != 0) for MUL; 0 for all other ops.
  - err = 0 except as described under Optional Feature.
- Single-cycle ops (000-110):
  - Outputs are registered at E0; out_valid=1 for the cycle after E0. Latency 1.
  - in_ready stays 1, so back-to-back ops are accepted every cycle.
- MUL, FSM IDLE -> MUL -> IDLE:
  - At E0: load multiplicand/multiplier, clear the accumulator, set the counter to N, in_ready->0.
  - Each following edge: one shift-add iteration, counter decrements.
  - At edge E0+N: the final product is written to the outputs, out_valid=1 for one cycle, in_ready->1, FSM->IDLE.
  - A new op may be presented and accepted at edge E0+N+1.
  - The result is latched from the values captured at E0; later changes on a/b have no effect.
- Holding: result, result_hi and flags hold their last values until the next completion. out_valid is 0 outside completion cycles.
- Reset mid-MUL: the operation is aborted and no out_valid is produced. Outputs are cleared and in_ready=1 after the reset edge.
- Reset has priority over acceptance on the same edge.

Optional Feature:
ALU_MUL_EN.
- Defined: MUL behaves as above; err is always 0.
- Undefined: no multiplier logic or MUL FSM state is built. op 111 completes with latency 1: result=0, result_hi=0, carry=0, ovf=0, zero=1, err=1. in_ready never drops.

Decomposition:
- Package alu_seq_pkg:
  - op localparams/enum OP_ADD..OP_MUL (3-bit).
  - FSM state typedef {S_IDLE, S_MUL}.
- One natural sub-module: alu_shift_add_mul.
  - Ports: N-bit operands, start, 2N-bit product, done.
  - Instantiated only under ALU_MUL_EN.

Test Plan:
- N=4, ADD a=9, b=8 -> next cycle out_valid=1, result=1, carry=1, ovf=1, zero=0.
- SUB a=3, b=5 -> result=4'hE, carry=1, ovf=0. Then SUB a=5, b=5 -> result=0, zero=1, carry=0.
- MUL a=F, b=F:
  - in_ready=0 for 4 cycles; an in_valid ADD pulse during this window is ignored.
  - out_valid exactly at edge E0+4, with result_hi=E, result=1, ovf=1.
  - A further ADD is accepted on the next edge.
- Shifts: SHL a=0011, b=2 -> 1100. SHR a=1000, b=3 -> 0001. SHL b=5 -> 0, zero=1.
- Back-to-back OR, XOR, AND on consecutive cycles -> three consecutive out_valid pulses with the correct results. Then assert rst at MUL iteration 2 -> no out_valid, all outputs 0, in_ready=1.
- ALU_MUL_EN undefined: MUL a=3, b=2 -> latency 1, result=0, err=1, zero=1, in_ready stays 1.

Source files
------------

// File: rtl/alu_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_seq_pkg
// Description : Shared op encodings and controller state type for the
//               sequential ALU (alu_seq_n) and its multiplier.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_seq_pkg;

    // The first four ops are the legacy 2-bit encodings with op[2] = 0
    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_SUB = 3'b010;
    localparam logic [2:0] OP_XOR = 3'b011;
    localparam logic [2:0] OP_AND = 3'b100;
    localparam logic [2:0] OP_SHL = 3'b101;
    localparam logic [2:0] OP_SHR = 3'b110;
    localparam logic [2:0] OP_MUL = 3'b111;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_MUL  = 1'b1
    } state_t;

endpackage
`default_nettype wire

// File: rtl/alu_seq_n_if.sv
`default_nettype none
// ============================================================================
// Module      : alu_seq_n_if
// Description : Operand/op input handshake and result/flag bus of the
//               sequential ALU. master = operand source, slave = ALU.
// Revision    : 1.0 - initial release
// ============================================================================
interface alu_seq_n_if #(
    parameter int N = 4
);
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [2:0]   op;
    logic         out_valid;
    logic [N-1:0] result;
    logic [N-1:0] result_hi;
    logic         carry;
    logic         zero;
    logic         ovf;
    logic         err;

    modport master (
        output in_valid, a, b, op,
        input  in_ready, out_valid, result, result_hi, carry, zero, ovf, err
    );

    modport slave (
        input  in_valid, a, b, op,
        output in_ready, out_valid, result, result_hi, carry, zero, ovf, err
    );
endinterface
`default_nettype wire

// File: rtl/alu_shift_add_mul.sv
`default_nettype none
// ============================================================================
// Module      : alu_shift_add_mul
// Description : Unsigned N x N shift-add multiplier. start loads the operands;
//               each later edge performs one iteration. done is asserted in
//               the cycle of the final iteration, with product already showing
//               the completed 2N-bit result so the caller can register it on
//               that same edge (N edges after start).
// Revision    : 1.0 - initial release
// ============================================================================
module alu_shift_add_mul #(
    parameter int N = 4
) (
    input  wire logic           clk,
    input  wire logic           rst,
    input  wire logic           start,
    input  wire logic [N-1:0]   a,
    input  wire logic [N-1:0]   b,
    output logic      [2*N-1:0] product,
    output logic                done
);
    localparam int CW = $clog2(N + 1);

    logic [2*N-1:0] r_mcand;
    logic [2*N-1:0] r_acc;
    logic [N-1:0]   r_mplier;
    logic [CW-1:0]  r_cnt;
    logic           r_busy;
    logic [2*N-1:0] w_acc_next;

    assign w_acc_next = r_acc + (r_mplier[0] ? r_mcand : '0);
    assign product    = w_acc_next;
    assign done       = r_busy && (r_cnt == CW'(1));

    // Operand capture on start, then one shift-add step per edge
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mcand  <= '0;
            r_acc    <= '0;
            r_mplier <= '0;
            r_cnt    <= '0;
            r_busy   <= 1'b0;
        end else if (start) begin
            r_mcand  <= {{N{1'b0}}, a};
            r_mplier <= b;
            r_acc    <= '0;
            r_cnt    <= CW'(N);
            r_busy   <= 1'b1;
        end else if (r_busy) begin
            r_acc    <= w_acc_next;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt - CW'(1);
            if (r_cnt == CW'(1)) begin
                r_busy <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/alu_seq_n.sv
`default_nettype none
// ============================================================================
// Module      : alu_seq_n
// Description : Registered N-bit, 8-op ALU with valid/ready input handshake
//               and carry/zero/ovf/err flags. Ops 000-110 complete with
//               latency 1; MUL uses a multi-cycle shift-add multiplier.
//               Build option ALU_MUL_EN: when defined, the multiplier and its
//               controller state are built; when undefined, op 111 completes
//               in one cycle with err=1 and a zero result.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_seq_n
    import alu_seq_pkg::*;
#(
    parameter int N = 4
) (
    input wire logic    clk,
    input wire logic    rst,
    alu_seq_n_if.slave  bus
);
    logic         w_accept;
    logic         w_fire;
    logic [N:0]   w_sum;
    logic [N-1:0] w_res;
    logic [N-1:0] w_hi;
    logic         w_carry;
    logic         w_ovf;
    logic         w_err;

    assign w_accept = bus.in_valid && bus.in_ready;

`ifdef ALU_MUL_EN
    state_t         r_state;
    state_t         w_state_next;
    logic           w_mul_start;
    logic           w_mul_done;
    logic [2*N-1:0] w_prod;

    // Controller state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Controller next state: stay busy until the multiplier finishes
    always_comb begin
        w_state_next = r_state;
        w_mul_start  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept && (bus.op == OP_MUL)) begin
                    w_mul_start  = 1'b1;
                    w_state_next = S_MUL;
                end
            end
            S_MUL: begin
                if (w_mul_done) begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    assign bus.in_ready = (r_state == S_IDLE);

    alu_shift_add_mul #(
        .N (N)
    ) u_mul (
        .clk     (clk),
        .rst     (rst),
        .start   (w_mul_start),
        .a       (bus.a),
        .b       (bus.b),
        .product (w_prod),
        .done    (w_mul_done)
    );
`else
    assign bus.in_ready = 1'b1;
`endif

    // Next result/flags: single-cycle ops from the inputs, MUL from the multiplier
    always_comb begin
        w_sum   = '0;
        w_res   = '0;
        w_hi    = '0;
        w_carry = 1'b0;
        w_ovf   = 1'b0;
        w_err   = 1'b0;
        case (bus.op)
            OP_ADD: begin
                w_sum   = {1'b0, bus.a} + {1'b0, bus.b};
                w_res   = w_sum[N-1:0];
                w_carry = w_sum[N];
                w_ovf   = (bus.a[N-1] == bus.b[N-1]) && (w_res[N-1] != bus.a[N-1]);
            end
            OP_OR:  w_res = bus.a | bus.b;
            OP_SUB: begin
                w_res   = bus.a - bus.b;
                w_carry = (bus.a < bus.b);
                w_ovf   = (bus.a[N-1] != bus.b[N-1]) && (w_res[N-1] != bus.a[N-1]);
            end
            OP_XOR: w_res = bus.a ^ bus.b;
            OP_AND: w_res = bus.a & bus.b;
            // Shift amounts of N or more flush every bit out
            OP_SHL: w_res = (bus.b >= N'(N)) ? '0 : (bus.a << bus.b);
            OP_SHR: w_res = (bus.b >= N'(N)) ? '0 : (bus.a >> bus.b);
            OP_MUL: begin
`ifndef ALU_MUL_EN
                w_err = 1'b1;
`endif
            end
            default: w_err = 1'b0;
        endcase

        w_fire = w_accept;
`ifdef ALU_MUL_EN
        w_fire = (w_accept && (bus.op != OP_MUL)) || w_mul_done;
        if (w_mul_done) begin
            w_res   = w_prod[N-1:0];
            w_hi    = w_prod[2*N-1:N];
            w_carry = 1'b0;
            w_ovf   = |w_prod[2*N-1:N];
            w_err   = 1'b0;
        end
`endif
    end

    // Output registers: update on completion, otherwise hold
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.out_valid <= 1'b0;
            bus.result    <= '0;
            bus.result_hi <= '0;
            bus.carry     <= 1'b0;
            bus.zero      <= 1'b0;
            bus.ovf       <= 1'b0;
            bus.err       <= 1'b0;
        end else begin
            bus.out_valid <= w_fire;
            if (w_fire) begin
                bus.result    <= w_res;
                bus.result_hi <= w_hi;
                bus.carry     <= w_carry;
                bus.zero      <= ({w_hi, w_res} == '0);
                bus.ovf       <= w_ovf;
                bus.err       <= w_err;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_seq_n.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_seq_n
// Description : Self-checking bench for alu_seq_n (N=4) with a scoreboard of
//               expected {result_hi, result, carry, zero, ovf, err} vectors.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_alu_seq_n;
    import alu_seq_pkg::*;

    localparam int N = 4;
    localparam int W = 2 * N + 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    int           tests = 0;
    int           fails = 0;
    logic [W-1:0] sb_q [$];
    logic [W-1:0] exp_v;
    logic [W-1:0] obs_v;

    alu_seq_n_if #(.N(N)) bus ();

    alu_seq_n #(.N(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    assign obs_v = {bus.result_hi, bus.result, bus.carry, bus.zero, bus.ovf, bus.err};

    // Reference model in plain integer arithmetic
    function automatic logic [W-1:0] model(input int a, input int b, input logic [2:0] op);
        int m    = 1 << N;
        int half = 1 << (N - 1);
        int r    = 0;
        int hi   = 0;
        int sa;
        int sb;
        int sr;
        bit c = 1'b0;
        bit o = 1'b0;
        bit e = 1'b0;
        sa = (a >= half) ? a - m : a;
        sb = (b >= half) ? b - m : b;
        case (op)
            OP_ADD: begin
                r  = a + b;
                c  = (r >= m);
                r  = r % m;
                sr = sa + sb;
                o  = (sr >= half) || (sr < -half);
            end
            OP_OR:  r = a | b;
            OP_SUB: begin
                r  = (a - b + m) % m;
                c  = (a < b);
                sr = sa - sb;
                o  = (sr >= half) || (sr < -half);
            end
            OP_XOR: r = a ^ b;
            OP_AND: r = a & b;
            OP_SHL: r = (b >= N) ? 0 : (a * (1 << b)) % m;
            OP_SHR: r = (b >= N) ? 0 : a / (1 << b);
            default: begin
`ifdef ALU_MUL_EN
                r  = (a * b) % m;
                hi = (a * b) / m;
                o  = (hi != 0);
`else
                e  = 1'b1;
`endif
            end
        endcase
        return {hi[N-1:0], r[N-1:0], c, (r == 0) && (hi == 0), o, e};
    endfunction

    // Present one op for one edge; push its expectation when it must be accepted
    task automatic issue(input int a, input int b, input logic [2:0] op, input bit accept);
        bus.in_valid = 1'b1;
        bus.a        = a[N-1:0];
        bus.b        = b[N-1:0];
        bus.op       = op;
        if (accept) sb_q.push_back(model(a, b, op));
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        tests++;
        if ({bus.in_ready, bus.out_valid, obs_v} !== {1'b1, 1'b0, {W{1'b0}}}) begin
            fails++;
            $display("FAIL reset_state got rdy=%b ov=%b vec=%h want rdy=1 ov=0 vec=0",
                     bus.in_ready, bus.out_valid, obs_v);
        end
        rst = 1'b0;
    endtask

    task automatic test_add_sub();
        int          av [5] = '{9, 3, 5, 7, 8};
        int          bv [5] = '{8, 5, 5, 1, 1};
        logic [2:0]  ov [5] = '{OP_ADD, OP_SUB, OP_SUB, OP_ADD, OP_SUB};
        for (int i = 0; i < 5; i++) begin
            issue(av[i], bv[i], ov[i], 1'b1);
            tests++;
            if (bus.out_valid !== 1'b1) begin
                fails++;
                $display("FAIL add_sub_valid[%0d] got %b want 1", i, bus.out_valid);
            end
            exp_v = sb_q.pop_front();
            tests++;
            if (obs_v !== exp_v) begin
                fails++;
                $display("FAIL add_sub_result[%0d] got %h want %h", i, obs_v, exp_v);
            end
        end
    endtask

    task automatic test_shift();
        int          av [4] = '{3, 8, 3, 1};
        int          bv [4] = '{2, 3, 5, 4};
        logic [2:0]  ov [4] = '{OP_SHL, OP_SHR, OP_SHL, OP_SHL};
        for (int i = 0; i < 4; i++) begin
            issue(av[i], bv[i], ov[i], 1'b1);
            tests++;
            if (bus.out_valid !== 1'b1) begin
                fails++;
                $display("FAIL shift_valid[%0d] got %b want 1", i, bus.out_valid);
            end
            exp_v = sb_q.pop_front();
            tests++;
            if (obs_v !== exp_v) begin
                fails++;
                $display("FAIL shift_result[%0d] got %h want %h", i, obs_v, exp_v);
            end
        end
    endtask

    task automatic test_back_to_back();
        int          av [3] = '{12, 12, 12};
        int          bv [3] = '{5, 10, 6};
        logic [2:0]  ov [3] = '{OP_OR, OP_XOR, OP_AND};
        logic [W-1:0] last;
        for (int i = 0; i < 3; i++) begin
            issue(av[i], bv[i], ov[i], 1'b1);
            tests++;
            if (bus.out_valid !== 1'b1) begin
                fails++;
                $display("FAIL b2b_valid[%0d] got %b want 1", i, bus.out_valid);
            end
            exp_v = sb_q.pop_front();
            tests++;
            if (obs_v !== exp_v) begin
                fails++;
                $display("FAIL b2b_result[%0d] got %h want %h", i, obs_v, exp_v);
            end
        end
        last = model(12, 6, OP_AND);
        @(posedge clk);
        #1;
        tests++;
        if ({bus.out_valid, obs_v} !== {1'b0, last}) begin
            fails++;
            $display("FAIL hold got ov=%b vec=%h want ov=0 vec=%h", bus.out_valid, obs_v, last);
        end
    endtask

`ifdef ALU_MUL_EN
    task automatic test_mul();
        int av [3] = '{15, 6, 0};
        int bv [3] = '{15, 7, 9};
        for (int k = 0; k < 3; k++) begin
            issue(av[k], bv[k], OP_MUL, 1'b1);
            tests++;
            if ({bus.in_ready, bus.out_valid} !== 2'b00) begin
                fails++;
                $display("FAIL mul_busy_e0[%0d] got rdy=%b ov=%b want 0 0", k, bus.in_ready, bus.out_valid);
            end
            // An ADD offered while busy must be dropped, and must not disturb MUL
            bus.in_valid = 1'b1;
            bus.a        = 4'd1;
            bus.b        = 4'd1;
            bus.op       = OP_ADD;
            for (int i = 1; i <= 3; i++) begin
                @(posedge clk);
                #1;
                bus.in_valid = 1'b0;
                tests++;
                if ({bus.in_ready, bus.out_valid} !== 2'b00) begin
                    fails++;
                    $display("FAIL mul_busy[%0d] cyc %0d got rdy=%b ov=%b want 0 0",
                             k, i, bus.in_ready, bus.out_valid);
                end
            end
            @(posedge clk);
            #1;
            tests++;
            if ({bus.in_ready, bus.out_valid} !== 2'b11) begin
                fails++;
                $display("FAIL mul_done[%0d] got rdy=%b ov=%b want 1 1", k, bus.in_ready, bus.out_valid);
            end
            exp_v = sb_q.pop_front();
            tests++;
            if (obs_v !== exp_v) begin
                fails++;
                $display("FAIL mul_result[%0d] got %h want %h", k, obs_v, exp_v);
            end
        end
        issue(2, 3, OP_ADD, 1'b1);
        tests++;
        if (bus.out_valid !== 1'b1) begin
            fails++;
            $display("FAIL mul_next_valid got %b want 1", bus.out_valid);
        end
        exp_v = sb_q.pop_front();
        tests++;
        if (obs_v !== exp_v) begin
            fails++;
            $display("FAIL mul_next_result got %h want %h", obs_v, exp_v);
        end
    endtask

    task automatic test_mul_reset();
        issue(7, 3, OP_MUL, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        tests++;
        if ({bus.in_ready, bus.out_valid, obs_v} !== {1'b1, 1'b0, {W{1'b0}}}) begin
            fails++;
            $display("FAIL mul_reset_state got rdy=%b ov=%b vec=%h want rdy=1 ov=0 vec=0",
                     bus.in_ready, bus.out_valid, obs_v);
        end
        for (int i = 0; i < N + 2; i++) begin
            @(posedge clk);
            #1;
            tests++;
            if ({bus.out_valid, obs_v} !== {1'b0, {W{1'b0}}}) begin
                fails++;
                $display("FAIL mul_reset_quiet[%0d] got ov=%b vec=%h want ov=0 vec=0",
                         i, bus.out_valid, obs_v);
            end
        end
    endtask
`else
    task automatic test_mul_disabled();
        int          av [3] = '{3, 3, 0};
        int          bv [3] = '{2, 2, 0};
        logic [2:0]  ov [3] = '{OP_MUL, OP_ADD, OP_MUL};
        for (int i = 0; i < 3; i++) begin
            issue(av[i], bv[i], ov[i], 1'b1);
            tests++;
            if ({bus.in_ready, bus.out_valid} !== 2'b11) begin
                fails++;
                $display("FAIL nomul_valid[%0d] got rdy=%b ov=%b want 1 1", i, bus.in_ready, bus.out_valid);
            end
            exp_v = sb_q.pop_front();
            tests++;
            if (obs_v !== exp_v) begin
                fails++;
                $display("FAIL nomul_result[%0d] got %h want %h", i, obs_v, exp_v);
            end
        end
    endtask
`endif

    task automatic test_reset_priority();
        issue(9, 9, OP_ADD, 1'b1);
        exp_v = sb_q.pop_front();
        tests++;
        if (obs_v !== exp_v) begin
            fails++;
            $display("FAIL prio_setup got %h want %h", obs_v, exp_v);
        end
        rst = 1'b1;
        issue(1, 1, OP_ADD, 1'b0);
        rst = 1'b0;
        tests++;
        if ({bus.in_ready, bus.out_valid, obs_v} !== {1'b1, 1'b0, {W{1'b0}}}) begin
            fails++;
            $display("FAIL reset_priority got rdy=%b ov=%b vec=%h want rdy=1 ov=0 vec=0",
                     bus.in_ready, bus.out_valid, obs_v);
        end
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.a        = '0;
        bus.b        = '0;
        bus.op       = OP_ADD;
        test_reset();
        test_add_sub();
        test_shift();
        test_back_to_back();
`ifdef ALU_MUL_EN
        test_mul();
        test_mul_reset();
`else
        test_mul_disabled();
`endif
        test_reset_priority();
        tests++;
        if (sb_q.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain got %0d left want 0", sb_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
